// File: rtl/multi_timer_core_if.sv
// Command, readout and lap-FIFO signal bundle for multi_timer_core.
// No latency of its own; plain wires between decoder/display side and the core.
// No backpressure: commands are always accepted, laps are popped by the reader.
interface multi_timer_core_if #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2
);
    logic              cmd_valid;
    logic [2:0]        cmd_op;
    logic [CH_W-1:0]   cmd_ch;
    logic [5:0]        cmd_min;
    logic [5:0]        cmd_sec;
    logic [CH_W-1:0]   rd_ch;
    logic [5:0]        rd_min;
    logic [5:0]        rd_sec;
    logic [1:0]        rd_state;
    logic              rd_mode;
    logic [NUM_CH-1:0] done;
    logic [NUM_CH-1:0] alarm;
    logic              lap_valid;
    logic [CH_W-1:0]   lap_ch;
    logic [5:0]        lap_min;
    logic [5:0]        lap_sec;
    logic              lap_pop;
    logic              lap_drop;

    modport master (
        output cmd_valid, cmd_op, cmd_ch, cmd_min, cmd_sec, rd_ch, lap_pop,
        input  rd_min, rd_sec, rd_state, rd_mode, done, alarm,
               lap_valid, lap_ch, lap_min, lap_sec, lap_drop
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_ch, cmd_min, cmd_sec, rd_ch, lap_pop,
        output rd_min, rd_sec, rd_state, rd_mode, done, alarm,
               lap_valid, lap_ch, lap_min, lap_sec, lap_drop
    );
endinterface

// File: rtl/multi_timer_core.sv
// Multi-channel stopwatch/timer engine with shared tick, lap FIFO and done/alarm flags.
// Latency: command -> channel regs 1 edge, -> rd_* 2 edges; done/lap_drop pulse 1 edge after cause.
// No backpressure: commands always accepted; a LAP into a full FIFO without a pop is dropped.
// Optional feature macro: MULTI_TIMER_AUTORELOAD_EN (timers reload their preset on expiry).
module multi_timer_core #(
    parameter int NUM_CH    = 4,
    parameter int CH_W      = 2,
    parameter int TICK_DIV  = 100_000_000,
    parameter int LAP_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    multi_timer_core_if.slave bus
);
    localparam int TW = $clog2(TICK_DIV);
    localparam int PW = $clog2(LAP_DEPTH);
    localparam int EW = CH_W + 12;
`ifdef MULTI_TIMER_AUTORELOAD_EN
    localparam bit AUTORELOAD = 1'b1;
`else
    localparam bit AUTORELOAD = 1'b0;
`endif

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_PAUSE = 2'd2, ST_UP = 2'd3} st_e;

    localparam logic [2:0] OP_START = 3'd1, OP_PAUSE = 3'd2, OP_CLEAR = 3'd3, OP_LOAD = 3'd4,
                           OP_MODE  = 3'd5, OP_LAP   = 3'd6, OP_ACK   = 3'd7;

    logic [TW-1:0]     tick_cnt_q, tick_cnt_d;
    logic              tick;
    st_e               state_q [NUM_CH];
    st_e               state_d [NUM_CH];
    logic [5:0]        min_q [NUM_CH], min_d [NUM_CH], sec_q [NUM_CH], sec_d [NUM_CH];
    logic [5:0]        pmin_q [NUM_CH], pmin_d [NUM_CH], psec_q [NUM_CH], psec_d [NUM_CH];
    logic [NUM_CH-1:0] mode_q, mode_d, done_q, done_d;
    logic [5:0]        rd_min_q, rd_min_d, rd_sec_q, rd_sec_d;
    logic [1:0]        rd_state_q, rd_state_d;
    logic              rd_mode_q, rd_mode_d;
    logic [EW-1:0]     lap_mem_q [LAP_DEPTH];
    logic [EW-1:0]     lap_mem_d [LAP_DEPTH];
    logic [PW-1:0]     lap_wr_q, lap_wr_d, lap_rd_q, lap_rd_d;
    logic [PW:0]       lap_cnt_q, lap_cnt_d;
    logic              lap_drop_q, lap_drop_d;
    logic              lap_req, lap_push, lap_pop_ok;
    logic [EW-1:0]     lap_entry;

    function automatic logic [5:0] sat59(input logic [5:0] v);
        return (v > 6'd59) ? 6'd59 : v;
    endfunction

    // Free-running tick divider; only reset clears the phase.
    always_comb begin
        tick       = (tick_cnt_q == TW'(TICK_DIV - 1));
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    end

    // Per-channel next state: an addressed command takes priority over the tick step.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            state_d[i] = state_q[i];
            min_d[i]   = min_q[i];
            sec_d[i]   = sec_q[i];
            pmin_d[i]  = pmin_q[i];
            psec_d[i]  = psec_q[i];
            mode_d[i]  = mode_q[i];
            done_d[i]  = 1'b0;
            if (bus.cmd_valid && bus.cmd_ch == CH_W'(i)) begin
                case (bus.cmd_op)
                    OP_START: if (state_q[i] == ST_IDLE || state_q[i] == ST_PAUSE) begin
                        if (mode_q[i] && min_q[i] == 6'd0 && sec_q[i] == 6'd0) begin
                            done_d[i] = 1'b1;
                            if (AUTORELOAD) begin
                                state_d[i] = ST_RUN;
                                min_d[i]   = pmin_q[i];
                                sec_d[i]   = psec_q[i];
                            end else begin
                                state_d[i] = ST_UP;
                            end
                        end else begin
                            state_d[i] = ST_RUN;
                        end
                    end
                    OP_PAUSE: if (state_q[i] == ST_RUN) state_d[i] = ST_PAUSE;
                    OP_CLEAR: begin
                        state_d[i] = ST_IDLE;
                        min_d[i]   = mode_q[i] ? pmin_q[i] : 6'd0;
                        sec_d[i]   = mode_q[i] ? psec_q[i] : 6'd0;
                    end
                    OP_LOAD: if (state_q[i] == ST_IDLE || state_q[i] == ST_PAUSE) begin
                        pmin_d[i] = sat59(bus.cmd_min);
                        psec_d[i] = sat59(bus.cmd_sec);
                        min_d[i]  = sat59(bus.cmd_min);
                        sec_d[i]  = sat59(bus.cmd_sec);
                    end
                    OP_MODE: if (state_q[i] == ST_IDLE) begin
                        mode_d[i] = ~mode_q[i];
                        min_d[i]  = mode_q[i] ? 6'd0 : pmin_q[i];
                        sec_d[i]  = mode_q[i] ? 6'd0 : psec_q[i];
                    end
                    OP_ACK: if (state_q[i] == ST_UP) begin
                        state_d[i] = ST_IDLE;
                        min_d[i]   = pmin_q[i];
                        sec_d[i]   = psec_q[i];
                    end
                    default: ;
                endcase
            end else if (tick && state_q[i] == ST_RUN) begin
                if (!mode_q[i]) begin
                    if (sec_q[i] == 6'd59) begin
                        sec_d[i] = 6'd0;
                        min_d[i] = (min_q[i] == 6'd59) ? 6'd0 : min_q[i] + 6'd1;
                    end else begin
                        sec_d[i] = sec_q[i] + 6'd1;
                    end
                end else begin
                    if (sec_q[i] == 6'd0) begin
                        sec_d[i] = 6'd59;
                        min_d[i] = min_q[i] - 6'd1;
                    end else begin
                        sec_d[i] = sec_q[i] - 6'd1;
                    end
                    // Reaching 00:00 (or sitting there after a zero-preset reload) expires the timer.
                    if (min_q[i] == 6'd0 && sec_q[i] <= 6'd1) begin
                        done_d[i] = 1'b1;
                        if (AUTORELOAD) begin
                            min_d[i] = pmin_q[i];
                            sec_d[i] = psec_q[i];
                        end else begin
                            state_d[i] = ST_UP;
                            min_d[i]   = 6'd0;
                            sec_d[i]   = 6'd0;
                        end
                    end
                end
            end
        end
    end

    // Lap FIFO control: a pop frees a slot in the same cycle, so full+pop+push is not a drop.
    always_comb begin
        lap_req   = 1'b0;
        lap_entry = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (bus.cmd_valid && bus.cmd_op == OP_LAP && bus.cmd_ch == CH_W'(i) &&
                (state_q[i] == ST_RUN || state_q[i] == ST_PAUSE)) begin
                lap_req   = 1'b1;
                lap_entry = {bus.cmd_ch, min_q[i], sec_q[i]};
            end
        end
        lap_pop_ok = bus.lap_pop && (lap_cnt_q != '0);
        lap_push   = lap_req && (lap_cnt_q != (PW+1)'(LAP_DEPTH) || lap_pop_ok);
        lap_drop_d = lap_req && !lap_push;
        lap_wr_d   = lap_push ? lap_wr_q + 1'b1 : lap_wr_q;
        lap_rd_d   = lap_pop_ok ? lap_rd_q + 1'b1 : lap_rd_q;
        lap_cnt_d  = lap_cnt_q;
        if (lap_push && !lap_pop_ok) lap_cnt_d = lap_cnt_q + 1'b1;
        if (!lap_push && lap_pop_ok) lap_cnt_d = lap_cnt_q - 1'b1;
        lap_mem_d = lap_mem_q;
        if (lap_push) lap_mem_d[lap_wr_q] = lap_entry;
    end

    // Readout mux for the selected channel; out-of-range selects read as zero.
    always_comb begin
        rd_min_d   = '0;
        rd_sec_d   = '0;
        rd_state_d = '0;
        rd_mode_d  = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (bus.rd_ch == CH_W'(i)) begin
                rd_min_d   = min_q[i];
                rd_sec_d   = sec_q[i];
                rd_state_d = state_q[i];
                rd_mode_d  = mode_q[i];
            end
        end
    end

    // Channel registers and tick phase.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt_q <= '0;
            mode_q     <= '0;
            done_q     <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= ST_IDLE;
                min_q[i]   <= '0;
                sec_q[i]   <= '0;
                pmin_q[i]  <= '0;
                psec_q[i]  <= 6'd59;
            end
        end else begin
            tick_cnt_q <= tick_cnt_d;
            mode_q     <= mode_d;
            done_q     <= done_d;
            state_q    <= state_d;
            min_q      <= min_d;
            sec_q      <= sec_d;
            pmin_q     <= pmin_d;
            psec_q     <= psec_d;
        end
    end

    // Lap FIFO storage, pointers and registered readout.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lap_wr_q   <= '0;
            lap_rd_q   <= '0;
            lap_cnt_q  <= '0;
            lap_drop_q <= 1'b0;
            rd_min_q   <= '0;
            rd_sec_q   <= '0;
            rd_state_q <= '0;
            rd_mode_q  <= 1'b0;
            for (int i = 0; i < LAP_DEPTH; i++) lap_mem_q[i] <= '0;
        end else begin
            lap_wr_q   <= lap_wr_d;
            lap_rd_q   <= lap_rd_d;
            lap_cnt_q  <= lap_cnt_d;
            lap_drop_q <= lap_drop_d;
            rd_min_q   <= rd_min_d;
            rd_sec_q   <= rd_sec_d;
            rd_state_q <= rd_state_d;
            rd_mode_q  <= rd_mode_d;
            lap_mem_q  <= lap_mem_d;
        end
    end

    // Alarm follows TIME_UP directly.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) bus.alarm[i] = (state_q[i] == ST_UP);
    end

    assign bus.done      = done_q;
    assign bus.rd_min    = rd_min_q;
    assign bus.rd_sec    = rd_sec_q;
    assign bus.rd_state  = rd_state_q;
    assign bus.rd_mode   = rd_mode_q;
    assign bus.lap_valid = (lap_cnt_q != '0);
    assign {bus.lap_ch, bus.lap_min, bus.lap_sec} = lap_mem_q[lap_rd_q];
    assign bus.lap_drop  = lap_drop_q;
endmodule

// File: tb/tb_multi_timer_core.sv
// Scoreboard bench for multi_timer_core: seconds-based reference model, decoupled monitor.
module tb_multi_timer_core;
    localparam int NUM_CH = 3;
    localparam int CH_W = 2;
    localparam int TICK_DIV = 4;
    localparam int LAP_DEPTH = 4;
`ifdef MULTI_TIMER_AUTORELOAD_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif
    localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_UP = 3;
    localparam int NOP = 0, START = 1, PAUSE = 2, CLEAR = 3, LOAD = 4, MODE = 5, LAP = 6, ACK = 7;

    typedef struct {
        int cyc; int mn; int sc; int st; int md; int al;
    } snap_t;
    typedef struct {
        int cyc; int mask;
    } evt_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;
    int rd_sel = 0;

    multi_timer_core_if #(.NUM_CH(NUM_CH), .CH_W(CH_W)) bus ();

    multi_timer_core #(.NUM_CH(NUM_CH), .CH_W(CH_W), .TICK_DIV(TICK_DIV), .LAP_DEPTH(LAP_DEPTH)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Reference model: time kept as total seconds per channel.
    int m_st [NUM_CH];
    int m_t  [NUM_CH];
    int m_pre[NUM_CH];
    int m_md [NUM_CH];
    int m_cnt;

    snap_t snap_q[$];
    evt_t  done_q[$];
    int    drop_q[$];
    int    exp_lap[$];

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, edge_cnt);
        end
    endfunction

    function automatic int sat(input int v);
        return (v > 59) ? 59 : v;
    endfunction

    function automatic void model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_st[c] = S_IDLE; m_t[c] = 0; m_pre[c] = 59; m_md[c] = 0;
        end
        m_cnt = 0;
    endfunction

    function automatic int expire(input int c);
        if (AR) begin
            m_t[c] = m_pre[c];
            m_st[c] = S_RUN;
        end else begin
            m_t[c] = 0;
            m_st[c] = S_UP;
        end
        return 1 << c;
    endfunction

    // Advance the model over one clock edge and queue the expected responses.
    function automatic void model_edge(input int op, input int ch, input int mn, input int sc, input bit pop);
        snap_t s;
        evt_t e;
        int dmask = 0;
        bit tick = (m_cnt == TICK_DIV - 1);
        bit lapreq = 0;
        int lap_val = 0;
        int cnt;
        s.cyc = edge_cnt + 1;
        s.mn = m_t[rd_sel] / 60; s.sc = m_t[rd_sel] % 60;
        s.st = m_st[rd_sel];     s.md = m_md[rd_sel];
        if (op == LAP && ch < NUM_CH && (m_st[ch] == S_RUN || m_st[ch] == S_PAUSE)) begin
            lapreq = 1;
            lap_val = (ch << 12) | ((m_t[ch] / 60) << 6) | (m_t[ch] % 60);
        end
        for (int c = 0; c < NUM_CH; c++) begin
            if (op != NOP && c == ch) begin
                case (op)
                    START: if (m_st[c] == S_IDLE || m_st[c] == S_PAUSE) begin
                        if (m_md[c] == 1 && m_t[c] == 0) dmask |= expire(c);
                        else m_st[c] = S_RUN;
                    end
                    PAUSE: if (m_st[c] == S_RUN) m_st[c] = S_PAUSE;
                    CLEAR: begin m_st[c] = S_IDLE; m_t[c] = m_md[c] ? m_pre[c] : 0; end
                    LOAD: if (m_st[c] == S_IDLE || m_st[c] == S_PAUSE) begin
                        m_pre[c] = sat(mn) * 60 + sat(sc); m_t[c] = m_pre[c];
                    end
                    MODE: if (m_st[c] == S_IDLE) begin
                        m_md[c] = 1 - m_md[c]; m_t[c] = m_md[c] ? m_pre[c] : 0;
                    end
                    ACK: if (m_st[c] == S_UP) begin m_st[c] = S_IDLE; m_t[c] = m_pre[c]; end
                    default: ;
                endcase
            end else if (tick && m_st[c] == S_RUN) begin
                if (m_md[c] == 0) m_t[c] = (m_t[c] + 1) % 3600;
                else if (m_t[c] == 0) dmask |= expire(c);
                else begin
                    m_t[c] = m_t[c] - 1;
                    if (m_t[c] == 0) dmask |= expire(c);
                end
            end
        end
        cnt = exp_lap.size();
        if (lapreq) begin
            if (cnt < LAP_DEPTH || (pop && cnt > 0)) exp_lap.push_back(lap_val);
            else drop_q.push_back(edge_cnt + 1);
        end
        m_cnt = (m_cnt + 1) % TICK_DIV;
        s.al = 0;
        for (int c = 0; c < NUM_CH; c++) if (m_st[c] == S_UP) s.al |= (1 << c);
        snap_q.push_back(s);
        if (dmask != 0) begin
            e.cyc = edge_cnt + 1; e.mask = dmask;
            done_q.push_back(e);
        end
    endfunction

    task automatic step(input int op, input int ch, input int mn, input int sc, input bit pop);
        bus.cmd_valid = (op != NOP);
        bus.cmd_op    = 3'(op);
        bus.cmd_ch    = CH_W'(ch);
        bus.cmd_min   = 6'(mn);
        bus.cmd_sec   = 6'(sc);
        bus.lap_pop   = pop;
        bus.rd_ch     = CH_W'(rd_sel);
        model_edge(op, ch, mn, sc, pop);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(NOP, 0, 0, 0, 1'b0);
    endtask

    task automatic do_reset(input bit check);
        reset = 1'b1;
        #2;
        if (check) begin
            chk("reset_rd_min", int'(bus.rd_min), 0);
            chk("reset_rd_sec", int'(bus.rd_sec), 0);
            chk("reset_rd_state", int'(bus.rd_state), S_IDLE);
            chk("reset_lap_valid", int'(bus.lap_valid), 0);
            chk("reset_alarm", int'(bus.alarm), 0);
        end
        snap_q.delete(); done_q.delete(); drop_q.delete(); exp_lap.delete();
        model_reset();
        bus.cmd_valid = 1'b0;
        bus.lap_pop = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Monitor: compares DUT outputs against queued expectations.
    snap_t mon_s;
    evt_t  mon_e;
    int    exp_done, exp_drop;
    always @(negedge clk) begin
        if (!reset) begin
            if (snap_q.size() > 0 && snap_q[0].cyc == edge_cnt) begin
                mon_s = snap_q.pop_front();
                chk("rd_min", int'(bus.rd_min), mon_s.mn);
                chk("rd_sec", int'(bus.rd_sec), mon_s.sc);
                chk("rd_state", int'(bus.rd_state), mon_s.st);
                chk("rd_mode", int'(bus.rd_mode), mon_s.md);
                chk("alarm", int'(bus.alarm), mon_s.al);
            end
            exp_done = 0;
            if (done_q.size() > 0 && done_q[0].cyc == edge_cnt) begin
                mon_e = done_q.pop_front();
                exp_done = mon_e.mask;
            end
            if (bus.done != '0 || exp_done != 0) chk("done", int'(bus.done), exp_done);
            exp_drop = 0;
            if (drop_q.size() > 0 && drop_q[0] == edge_cnt) begin
                void'(drop_q.pop_front());
                exp_drop = 1;
            end
            if (bus.lap_drop || exp_drop != 0) chk("lap_drop", int'(bus.lap_drop), exp_drop);
            if (bus.lap_valid && bus.lap_pop) begin
                if (exp_lap.size() == 0) chk("lap_unexpected_entry", int'(bus.lap_valid), 0);
                else chk("lap_entry", int'({bus.lap_ch, bus.lap_min, bus.lap_sec}), exp_lap.pop_front());
            end
        end
    end

    initial begin
        bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_ch = '0;
        bus.cmd_min = '0; bus.cmd_sec = '0; bus.rd_ch = '0; bus.lap_pop = 1'b0;
        #1;
        do_reset(1'b1);
        idle(2);

        // Stopwatch wrap from 59:58.
        rd_sel = 0;
        step(LOAD, 0, 59, 58, 1'b0);
        step(START, 0, 0, 0, 1'b0);
        idle(2 * TICK_DIV + 2);

        // Timer expiry and ACK.
        rd_sel = 1;
        step(MODE, 1, 0, 0, 1'b0);
        step(LOAD, 1, 0, 2, 1'b0);
        step(START, 1, 0, 0, 1'b0);
        idle(3 * TICK_DIV);
        step(ACK, 1, 0, 0, 1'b0);
        idle(2);

        // Command beats tick for the addressed channel only.
        rd_sel = 2;
        step(START, 2, 0, 0, 1'b0);
        idle(TICK_DIV + 1);
        for (int k = 0; k < TICK_DIV && m_cnt != TICK_DIV - 1; k++) idle(1);
        step(PAUSE, 2, 0, 0, 1'b0);
        rd_sel = 0;
        idle(2);
        step(LOAD, 2, 63, 60, 1'b0);
        rd_sel = 2;
        idle(2);

        // Lap FIFO: overflow drop, then full with simultaneous pop.
        repeat (5) step(LAP, 0, 0, 0, 1'b0);
        repeat (5) step(NOP, 0, 0, 0, 1'b1);
        repeat (4) step(LAP, 2, 0, 0, 1'b0);
        step(LAP, 0, 0, 0, 1'b1);
        repeat (5) step(NOP, 0, 0, 0, 1'b1);

        // Autoreload / repeated expiry with preset 00:01.
        rd_sel = 1;
        step(LOAD, 1, 0, 1, 1'b0);
        step(START, 1, 0, 0, 1'b0);
        idle(3 * TICK_DIV);
        step(CLEAR, 1, 0, 0, 1'b0);

        // Randomised traffic, including ignored channel 3 and saturating loads.
        for (int k = 0; k < 600; k++) begin
            int op;
            rd_sel = $urandom_range(0, NUM_CH - 1);
            op = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : NOP;
            step(op, $urandom_range(0, 3), $urandom_range(0, 63), $urandom_range(0, 63),
                 1'($urandom_range(0, 2) == 0));
        end

        // Reset while ch0 runs at 03:17.
        rd_sel = 0;
        step(CLEAR, 0, 0, 0, 1'b0);
        if (m_md[0] == 1) step(MODE, 0, 0, 0, 1'b0);
        step(LOAD, 0, 3, 15, 1'b0);
        step(START, 0, 0, 0, 1'b0);
        for (int k = 0; k < 20 * TICK_DIV && m_t[0] != 197; k++) idle(1);
        chk("reach_03_17", m_t[0], 197);
        step(LAP, 0, 0, 0, 1'b0);
        do_reset(1'b1);
        step(MODE, 0, 0, 0, 1'b0);
        idle(3);

        // Drain and confirm every expectation was consumed.
        repeat (LAP_DEPTH + 2) step(NOP, 0, 0, 0, 1'b1);
        idle(2);
        chk("lap_leftover", exp_lap.size(), 0);
        chk("done_leftover", done_q.size(), 0);
        chk("drop_leftover", drop_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
